// File: rtl/pdp8_mem_pkg.sv
// Shared types and constants for the PDP-8 memory sequencer: operation codes,
// word width, the auto-index page marker and the sequencer state encoding.
package pdp8_mem_pkg;

    localparam int WORD = 12;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ISZ   = 2'b10;

    // Offsets 0010-0017 share this upper 9-bit pattern.
    localparam logic [8:0] AUTOIDX_HI = 9'o001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_IRD,
        S_IWAIT,
        S_IWB,
        S_RD,
        S_RWAIT,
        S_WB,
        S_WR,
        S_RESP
    } state_t;

    function automatic logic is_autoidx(input logic [WORD-1:0] offset);
        return offset[WORD-1:3] == AUTOIDX_HI;
    endfunction

endpackage

// File: rtl/mem_sequencer.sv
// CPU-side initiator for the 12-bit core array: one READ/WRITE/ISZ at a time,
// with optional indirect pointer resolution and auto-index at 0010-0017.
module mem_sequencer
    import pdp8_mem_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_indirect,
    input  logic [2:0]      req_ifield,
    input  logic [2:0]      req_dfield,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_data,
    output logic [AW-1:0]   rsp_eaddr,
    output logic            rsp_skip,
    output logic [AW-1:0]   mem_raddr,
    output logic [AW-1:0]   mem_waddr,
    output logic            mem_wren,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
);

    state_t          state_reg;
    logic [1:0]      op_reg;
    logic [2:0]      ifield_reg;
    logic [2:0]      dfield_reg;
    logic [WORD-1:0] addr_reg;
    logic [WORD-1:0] wdata_reg;
    logic [AW-1:0]   eaddr_reg;
    logic [WORD-1:0] val_reg;

    // One incrementer serves both the auto-index pointer and the ISZ operand,
    // since both always increment whatever the array just returned.
    logic [WORD-1:0] rdata_inc;
    logic [WORD-1:0] ptr_next;
    logic [AW-1:0]   ptr_loc;
    logic [AW-1:0]   ptr_ea;
    logic [AW-1:0]   req_loc;
    logic            op_is_write;
    logic            op_is_isz;

    always_comb begin
        rdata_inc   = mem_rdata + WORD'(1);
        ptr_next    = is_autoidx(addr_reg) ? rdata_inc : mem_rdata;
        ptr_loc     = AW'({ifield_reg, addr_reg});
        ptr_ea      = AW'({dfield_reg, ptr_next});
        req_loc     = AW'({req_ifield, req_addr});
        op_is_write = (op_reg == OP_WRITE);
        op_is_isz   = (op_reg == OP_ISZ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            req_ready  <= 1'b1;
            op_reg     <= OP_READ;
            ifield_reg <= '0;
            dfield_reg <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            eaddr_reg  <= '0;
            val_reg    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_eaddr  <= '0;
            rsp_skip   <= 1'b0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wren   <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            mem_wren  <= 1'b0;
            rsp_valid <= 1'b0;

            unique case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        op_reg     <= req_op;
                        ifield_reg <= req_ifield;
                        dfield_reg <= req_dfield;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        eaddr_reg  <= req_loc;
                        if (req_indirect) begin
                            state_reg <= S_IRD;
                            mem_raddr <= req_loc;
                        end else if (req_op == OP_WRITE) begin
                            state_reg <= S_WR;
                            mem_wren  <= 1'b1;
                            mem_waddr <= req_loc;
                            mem_wdata <= req_wdata;
                        end else begin
                            state_reg <= S_RD;
                            mem_raddr <= req_loc;
                        end
                    end
                end

                S_IRD: state_reg <= S_IWAIT;

                S_IWAIT: begin
                    eaddr_reg <= ptr_ea;
                    if (is_autoidx(addr_reg)) begin
                        state_reg <= S_IWB;
                        mem_wren  <= 1'b1;
                        mem_waddr <= ptr_loc;
                        mem_wdata <= ptr_next;
                    end else if (op_is_write) begin
                        state_reg <= S_WR;
                        mem_wren  <= 1'b1;
                        mem_waddr <= ptr_ea;
                        mem_wdata <= wdata_reg;
                    end else begin
                        state_reg <= S_RD;
                        mem_raddr <= ptr_ea;
                    end
                end

                S_IWB: begin
                    if (op_is_write) begin
                        state_reg <= S_WR;
                        mem_wren  <= 1'b1;
                        mem_waddr <= eaddr_reg;
                        mem_wdata <= wdata_reg;
                    end else begin
                        state_reg <= S_RD;
                        mem_raddr <= eaddr_reg;
                    end
                end

                S_RD: state_reg <= S_RWAIT;

                S_RWAIT: begin
                    if (op_is_isz) begin
                        state_reg <= S_WB;
                        val_reg   <= rdata_inc;
                        mem_wren  <= 1'b1;
                        mem_waddr <= eaddr_reg;
                        mem_wdata <= rdata_inc;
                    end else begin
                        state_reg <= S_RESP;
                        val_reg   <= mem_rdata;
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rdata;
                        rsp_eaddr <= eaddr_reg;
                        rsp_skip  <= 1'b0;
                    end
                end

                S_WB: begin
                    state_reg <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= val_reg;
                    rsp_eaddr <= eaddr_reg;
                    rsp_skip  <= (val_reg == '0);
                end

                S_WR: begin
                    state_reg <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= wdata_reg;
                    rsp_eaddr <= eaddr_reg;
                    rsp_skip  <= 1'b0;
                end

                S_RESP: begin
                    state_reg <= S_IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state_reg <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized bench for mem_sequencer: a registered-read array model plus a
// word-level reference model of READ/WRITE/ISZ with indirection and auto-index.
module tb_mem_sequencer;
    import pdp8_mem_pkg::*;

    localparam int AW = 15;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = '0;
    logic            req_indirect = 1'b0;
    logic [2:0]      req_ifield = '0;
    logic [2:0]      req_dfield = '0;
    logic [11:0]     req_addr = '0;
    logic [11:0]     req_wdata = '0;
    logic            rsp_valid;
    logic [11:0]     rsp_data;
    logic [AW-1:0]   rsp_eaddr;
    logic            rsp_skip;
    logic [AW-1:0]   mem_raddr;
    logic [AW-1:0]   mem_waddr;
    logic            mem_wren;
    logic [11:0]     mem_wdata;
    logic [11:0]     mem_rdata;

    mem_sequencer #(.AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_indirect(req_indirect), .req_ifield(req_ifield), .req_dfield(req_dfield),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_eaddr(rsp_eaddr), .rsp_skip(rsp_skip),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wren(mem_wren),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] init_word(input int i);
        return 12'((i * 2749 + 7) ^ (i >> 5));
    endfunction

    // Array model: bulk init, backdoor poke, DUT write, 1-cycle registered read.
    logic [11:0]   mem [0:32767];
    logic          init_en = 1'b0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [11:0]   bd_data = '0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 32768; i++) mem[i] <= init_word(i);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_wren) begin
            mem[mem_waddr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_raddr];
    end

    int wr_total = 0;
    int rsp_total = 0;
    always @(posedge clk) begin
        if (mem_wren) wr_total++;
        if (rsp_valid) rsp_total++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    logic [11:0] ref_mem [0:32767];
    logic [11:0] last_data;
    logic [AW-1:0] last_eaddr;

    task automatic poke(input logic [AW-1:0] a, input logic [11:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic run_op(input logic [1:0] op, input logic ind, input logic [2:0] ifl,
                          input logic [2:0] dfl, input logic [11:0] a, input logic [11:0] wd);
        logic [AW-1:0] ea;
        logic [11:0]   ptr, edata;
        logic          eskip;
        int            elat, ewr, n, got, wr_before;

        // Reference: apply the operation to ref_mem word by word.
        ea = {ifl, a}; elat = 0; ewr = 0; eskip = 1'b0;
        if (ind) begin
            ptr = ref_mem[{ifl, a}];
            elat += 2;
            if (a >= 12'o0010 && a <= 12'o0017) begin
                ptr = 12'((int'(ptr) + 1) % 4096);
                ref_mem[{ifl, a}] = ptr;
                elat += 1; ewr += 1;
            end
            ea = {dfl, ptr};
        end
        if (op == OP_WRITE) begin
            ref_mem[ea] = wd; edata = wd; elat += 2; ewr += 1;
        end else if (op == OP_ISZ) begin
            edata = 12'((int'(ref_mem[ea]) + 1) % 4096);
            ref_mem[ea] = edata; eskip = (edata == 12'o0000);
            elat += 4; ewr += 1;
        end else begin
            edata = ref_mem[ea]; elat += 3;
        end

        @(negedge clk);
        chk("ready_before", int'(req_ready), 1);
        req_valid = 1'b1; req_op = op; req_indirect = ind;
        req_ifield = ifl; req_dfield = dfl; req_addr = a; req_wdata = wd;
        @(posedge clk);
        wr_before = wr_total;
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); req_indirect = 1'($urandom);
        req_ifield = 3'($urandom); req_dfield = 3'($urandom);
        req_addr = 12'($urandom); req_wdata = 12'($urandom);

        n = 0; got = 0;
        while (n < 20 && got == 0) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1;
        end
        chk("rsp_seen", got, 1);
        if (got != 0) begin
            chk("latency", n, elat);
            chk("rsp_data", int'(rsp_data), int'(edata));
            chk("rsp_eaddr", int'(rsp_eaddr), int'(ea));
            chk("rsp_skip", int'(rsp_skip), int'(eskip));
            chk("write_count", wr_total - wr_before, ewr);
        end
        last_data = rsp_data;
        last_eaddr = rsp_eaddr;
        @(negedge clk);
        chk("rsp_single", int'(rsp_valid), 0);
        chk("ready_after", int'(req_ready), 1);
        chk("rsp_hold", int'(rsp_data), int'(edata));
        chk("mem_operand", int'(mem[ea]), int'(ref_mem[ea]));
        if (ind) chk("mem_pointer", int'(mem[{ifl, a}]), int'(ref_mem[{ifl, a}]));
        $display("txn op=%0d ind=%0d if=%0o df=%0o addr=%04o -> data=%04o eaddr=%05o skip=%0d lat=%0d",
                 op, ind, ifl, dfl, a, rsp_data, rsp_eaddr, rsp_skip, n);
    endtask

    task automatic reset_during_wb();
        int n, rsp_before;
        poke(15'o00600, 12'o0005);
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_ISZ; req_indirect = 1'b0;
        req_ifield = 3'o0; req_addr = 12'o0600;
        @(posedge clk);
        rsp_before = rsp_total;
        #1 req_valid = 1'b0;
        n = 0;
        while (n < 10 && mem_wren !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wb_reached", int'(mem_wren), 1);
        reset = 1'b1;
        #1;
        chk("rst_wren_drop", int'(mem_wren), 0);
        chk("rst_rsp_low", int'(rsp_valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", int'(req_ready), 1);
        repeat (5) @(negedge clk);
        chk("rst_no_rsp", rsp_total - rsp_before, 0);
        chk("rst_write_aborted", int'(mem[15'o00600]), 8'o005);
        $display("txn reset during ISZ write-back at 0:0600, mem=%04o", mem[15'o00600]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [11:0] a;
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
        init_en = 1'b1;
        @(posedge clk);
        #1 init_en = 1'b0;

        @(negedge clk);
        chk("reset_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_wren", int'(mem_wren), 0);
        chk("reset_rsp_data", int'(rsp_data), 0);
        reset = 1'b0;

        poke(15'o00200, 12'o1234);
        run_op(OP_READ, 1'b0, 3'o0, 3'o0, 12'o0200, 12'o0);
        chk("tp_read_data", int'(last_data), 12'o1234);
        chk("tp_read_eaddr", int'(last_eaddr), 15'o00200);

        run_op(OP_WRITE, 1'b0, 3'o2, 3'o0, 12'o0300, 12'o5555);
        chk("tp_write_eaddr", int'(last_eaddr), 15'o20300);
        run_op(OP_READ, 1'b0, 3'o2, 3'o0, 12'o0300, 12'o0);
        chk("tp_readback", int'(last_data), 12'o5555);

        poke(15'o00400, 12'o7777);
        run_op(OP_ISZ, 1'b0, 3'o0, 3'o0, 12'o0400, 12'o0);
        chk("tp_isz_wrap", int'(last_data), 12'o0000);
        poke(15'o00401, 12'o0001);
        run_op(OP_ISZ, 1'b0, 3'o0, 3'o0, 12'o0401, 12'o0);
        chk("tp_isz_inc", int'(last_data), 12'o0002);

        poke(15'o00010, 12'o0477);
        poke(15'o30500, 12'o0042);
        run_op(OP_READ, 1'b1, 3'o0, 3'o3, 12'o0010, 12'o0);
        chk("tp_autoidx_ptr", int'(mem[15'o00010]), 12'o0500);
        chk("tp_autoidx_data", int'(last_data), 12'o0042);

        poke(15'o00020, 12'o0477);
        run_op(OP_READ, 1'b1, 3'o0, 3'o3, 12'o0020, 12'o0);
        chk("tp_noauto_eaddr", int'(last_eaddr), 15'o30477);
        poke(15'o00007, 12'o0100);
        run_op(OP_READ, 1'b1, 3'o0, 3'o1, 12'o0007, 12'o0);

        poke(15'o00017, 12'o7777);
        run_op(OP_READ, 1'b1, 3'o0, 3'o5, 12'o0017, 12'o0);
        chk("tp_autoidx_wrap", int'(last_eaddr), 15'o50000);
        poke(15'o40013, 12'o0123);
        run_op(OP_WRITE, 1'b1, 3'o4, 3'o6, 12'o0013, 12'o4321);
        run_op(OP_ISZ, 1'b0, 3'o7, 3'o0, 12'o7777, 12'o0);
        run_op(2'b11, 1'b0, 3'o0, 3'o0, 12'o0200, 12'o0);

        reset_during_wb();
        run_op(OP_ISZ, 1'b0, 3'o0, 3'o0, 12'o0600, 12'o0);

        for (int t = 0; t < 250; t++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: a = 12'(12'o0010 + $urandom_range(0, 7));
                1: a = ($urandom_range(0, 1) == 0) ? 12'o0007 : 12'o0020;
                default: a = 12'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 7) == 0) poke({3'($urandom_range(0, 1)), a}, 12'o7777);
            run_op(op, 1'($urandom), 3'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                   a, 12'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- CPU-side initiator for the 12-bit core memory array.
- Accepts one PDP-8 memory operation at a time over a valid/ready request port: read, write or ISZ.
- Optionally resolves an indirect pointer first, including auto-index at locations 0010–0017.
- Drives the array's raddr/waddr/wren/wdata and consumes its 1-cycle registered rdata; returns a single-cycle response pulse.

Parameters:
AW, 15, memory address width (3-bit field + 12-bit offset = 32K words); equals `MEM_AWIDTH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle; request accepted when req_valid && req_ready at posedge
req_op  in  2  00 READ, 01 WRITE, 10 ISZ, 11 reserved (treated as READ)
req_indirect  in  1  req_addr addresses a pointer, not the operand
req_ifield  in  3  instruction field (direct operand / pointer field)
req_dfield  in  3  data field (indirect operand field)
req_addr  in  12  offset within field
req_wdata  in  12  WRITE data
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  12  READ: operand; ISZ: incremented value; WRITE: req_wdata
rsp_eaddr  out  AW  effective operand address
rsp_skip  out  1  ISZ result == 0000
mem_raddr  out  AW  to array
mem_waddr  out  AW  to array
mem_wren  out  1  to array
mem_wdata  out  12  to array
mem_rdata  in  12  from array, valid the cycle after raddr is sampled

Behaviour:
- States: IDLE, IRD, IWAIT, IWB, RD, RWAIT, WB, WR, RESP.
- Reset values: all outputs 0 except req_ready. req_ready = 1 only in IDLE, so it is 1 after reset.
- IDLE: on accept, latch the request.
  - indirect → IRD.
  - WRITE → WR.
  - otherwise → RD.
  - Direct operand address = {req_ifield, req_addr}.
- IRD: mem_raddr = {ifield, addr} → IWAIT.
- IWAIT: ptr = mem_rdata.
  - If addr[11:3] == 9'o001 (auto-index): ptr = (mem_rdata + 1) mod 4096 → IWB.
  - Else → RD/WR.
  - eaddr = {dfield, ptr}.
- IWB: mem_wren = 1, waddr = {ifield, addr}, wdata = ptr → RD (READ/ISZ) or WR.
- RD: mem_raddr = eaddr → RWAIT.
- RWAIT: capture mem_rdata.
  - ISZ: value + 1 mod 4096 → WB.
  - Else → RESP.
- WB: mem_wren = 1, waddr = eaddr, wdata = incremented value → RESP.
- WR: mem_wren = 1, waddr = eaddr, wdata = req_wdata → RESP.
- RESP: rsp_valid = 1 for exactly one cycle with rsp_* stable → IDLE.
  - rsp_* hold their values until the next RESP.
  - The next request can be accepted the cycle after RESP.
- Latency, accept edge to rsp_valid high (clocks):
  - Direct: READ 3, WRITE 2, ISZ 4.
  - Indirect adds 2; auto-index adds 1 more.
- mem_wren is high only in IWB/WB/WR, at most one write per cycle, never combinational from inputs.
- Address ownership:
  - mem_raddr holds its last value outside IRD/RD.
  - mem_waddr/mem_wdata are don't-care when wren = 0, but are driven registered/decoded from state; no X.
- The sequencer never reads and writes the same address in one cycle. Read-during-write ordering of the array is irrelevant.
- Wrap-around:
  - 7777 + 1 = 0000 for both ISZ and auto-index.
  - ISZ of 7777 sets rsp_skip; rsp_skip = 0 for READ/WRITE.
- Pointer address 0007 and 0020 are NOT auto-index. Auto-index applies in any field (0010–0017 of ifield).
- Request inputs are ignored when not in IDLE; no backpressure on the response.
- Reset mid-operation: asynchronously return to IDLE and drop mem_wren/rsp_valid immediately. An in-flight write is aborted, a read-modify-write may be left half-done, and there is no replay.

Decomposition:
- Package pdp8_mem_pkg:
  - op encodings OP_READ/OP_WRITE/OP_ISZ.
  - AUTOIDX_HI = 9'o001.
  - state enum.
  - WORD = 12.
- Single flat module; the 12-bit incrementer is shared inline between the auto-index and ISZ paths. No sub-module.

Test Plan:
- Preload 0:0200 = 1234; direct READ ifield 0 addr 0200 → rsp_valid 3 clocks after accept, rsp_data 1234, rsp_eaddr 00200, no wren seen.
- Direct WRITE 5555 to field 2 addr 0300 → wren one cycle with waddr 20300; rsp_valid at +2; a follow-up READ returns 5555.
- ISZ on word 7777 at 0:0400 → memory becomes 0000, rsp_data 0000, rsp_skip 1, rsp at +4; ISZ on 0001 gives 0002, skip 0.
- Indirect READ: 0:0010 = 0477, dfield 3, 3:0500 = 0042 → pointer written to 0500, rsp_eaddr 30500, rsp_data 0042, rsp at +6. Same via 0:0020 = 0477 → no pointer write, eaddr 30477, rsp at +5.
- Auto-index wrap: 0:0017 = 7777 → pointer becomes 0000, eaddr {dfield, 0000}.
- Assert reset during WB of an ISZ → wren drops asynchronously, req_ready = 1 after release, rsp_valid never pulses, the next request completes normally.
